// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: memop sizes, exception codes, FSM states.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package mem_pkg;

    // Access size / sign encoding carried from decode
    localparam logic [2:0] MEMOP_W  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_HU = 3'b010;
    localparam logic [2:0] MEMOP_B  = 3'b011;
    localparam logic [2:0] MEMOP_BU = 3'b100;

    // Exception codes; load and store address errors share one code
    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_OV    = 2'b01;
    localparam logic [1:0] EXC_ALIGN = 2'b10;
    localparam logic [1:0] EXC_BUS   = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    function automatic logic is_half(input logic [2:0] op);
        return (op == MEMOP_H) || (op == MEMOP_HU);
    endfunction

    function automatic logic is_byte(input logic [2:0] op);
        return (op == MEMOP_B) || (op == MEMOP_BU);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between the memory stage and the memory.
// Latency: n/a (wires only).
// Backpressure: the master holds req and payload stable until ack is seen.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  memop,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Little-endian lane pick followed by extension per memop
    always_comb begin
        lane_b = rdata[7:0];
        case (addr)
            2'd0: lane_b = rdata[7:0];
            2'd1: lane_b = rdata[15:8];
            2'd2: lane_b = rdata[23:16];
            2'd3: lane_b = rdata[31:24];
            default: lane_b = rdata[7:0];
        endcase
        lane_h = addr[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (memop)
            MEMOP_H:  data = {{16{lane_h[15]}}, lane_h};
            MEMOP_HU: data = {16'h0000, lane_h};
            MEMOP_B:  data = {{24{lane_b[7]}}, lane_b};
            MEMOP_BU: data = {24'h000000, lane_b};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// EX/MEM register plus data-memory access, load alignment, exceptions and MEM/WB register.
// Latency: result registered one cycle after capture, or one cycle after ack for memory ops.
// Backpressure: mem_stall freezes upstream while a request waits for ack (bounded by TIMEOUT).
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ex_valid,
    input  logic [31:0] ex_aluresult,
    input  logic        ex_overflow,
    input  logic        ex_ovcheck,
    input  logic [31:0] ex_busb,
    input  logic        ex_memrd,
    input  logic        ex_memwr,
    input  logic [2:0]  ex_memop,
    input  logic        ex_memtoreg,
    input  logic        ex_regwr,
    input  logic [4:0]  ex_rw,

    output logic        mem_stall,
    mem_stage_if.master dmem,

    output logic        wb_valid,
    output logic        wb_regwr,
    output logic [4:0]  wb_rw,
    output logic [31:0] wb_data,

    output logic        exc_valid,
    output logic [1:0]  exc_code,
    output logic [31:0] exc_badaddr
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    // EX/MEM pipeline register
    logic        r_valid;
    logic [31:0] r_aluresult;
    logic        r_overflow;
    logic        r_ovcheck;
    logic [31:0] r_busb;
    logic        r_memrd;
    logic        r_memwr;
    logic [2:0]  r_memop;
    logic        r_memtoreg;
    logic        r_regwr;
    logic [4:0]  r_rw;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic        is_mem;
    logic        ov;
    logic        misalign;
    logic        req;
    logic        timeout_hit;
    logic        exc_any;
    logic [1:0]  exc_sel;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] aligned_load;

    assign is_mem   = r_memrd | r_memwr;
    assign ov       = r_ovcheck & r_overflow;
    assign misalign = is_mem &
                      ((is_half(r_memop) & r_aluresult[0]) |
                       (!is_half(r_memop) & !is_byte(r_memop) & (r_aluresult[1:0] != 2'b00)));

    // Excepting instructions never reach the bus
    assign req         = r_valid & is_mem & !ov & !misalign;
    assign timeout_hit = req & !dmem.ack & (cnt == TMO);
    assign mem_stall   = req & !dmem.ack & !timeout_hit;

    // Store lane steering; loads always read the whole word
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = r_busb;
        if (r_memwr) begin
            if (is_half(r_memop)) begin
                be_c    = r_aluresult[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{r_busb[15:0]}};
            end else if (is_byte(r_memop)) begin
                be_c    = 4'b0001 << r_aluresult[1:0];
                wdata_c = {4{r_busb[7:0]}};
            end
        end
    end

    assign dmem.req   = req;
    assign dmem.we    = req & r_memwr;
    assign dmem.addr  = {r_aluresult[31:2], 2'b00};
    assign dmem.be    = req ? be_c : 4'b0000;
    assign dmem.wdata = wdata_c;

    load_align u_load_align (
        .rdata (dmem.rdata),
        .addr  (r_aluresult[1:0]),
        .memop (r_memop),
        .data  (aligned_load)
    );

    // Exception priority: overflow, then misalignment, then bus timeout
    always_comb begin
        exc_sel = EXC_NONE;
        if (r_valid & ov)
            exc_sel = EXC_OV;
        else if (r_valid & misalign)
            exc_sel = EXC_ALIGN;
        else if (timeout_hit)
            exc_sel = EXC_BUS;
        exc_any = (exc_sel != EXC_NONE);
    end

    // Capture the next instruction from EX unless a memory access is outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_aluresult <= '0;
            r_overflow  <= 1'b0;
            r_ovcheck   <= 1'b0;
            r_busb      <= '0;
            r_memrd     <= 1'b0;
            r_memwr     <= 1'b0;
            r_memop     <= MEMOP_W;
            r_memtoreg  <= 1'b0;
            r_regwr     <= 1'b0;
            r_rw        <= '0;
        end else if (!mem_stall) begin
            r_valid     <= ex_valid;
            r_aluresult <= ex_aluresult;
            r_overflow  <= ex_overflow;
            r_ovcheck   <= ex_ovcheck;
            r_busb      <= ex_busb;
            r_memrd     <= ex_memrd;
            r_memwr     <= ex_memwr;
            r_memop     <= ex_memop;
            r_memtoreg  <= ex_memtoreg;
            r_regwr     <= ex_regwr;
            r_rw        <= ex_rw;
        end
    end

    // Access FSM: count wait cycles until ack or until the timeout fires
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req && !dmem.ack) begin
                        state <= ST_ACCESS;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_ACCESS: begin
                    if (!req || dmem.ack || timeout_hit) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // MEM/WB register and exception pulse; nothing retires while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_regwr    <= 1'b0;
            wb_rw       <= '0;
            wb_data     <= '0;
            exc_valid   <= 1'b0;
            exc_code    <= EXC_NONE;
            exc_badaddr <= '0;
        end else if (mem_stall) begin
            wb_valid  <= 1'b0;
            wb_regwr  <= 1'b0;
            exc_valid <= 1'b0;
        end else begin
            wb_valid    <= r_valid;
            wb_rw       <= r_rw;
            wb_data     <= r_memtoreg ? aligned_load : r_aluresult;
            wb_regwr    <= r_valid & r_regwr & !exc_any;
            exc_valid   <= exc_any;
            exc_code    <= exc_sel;
            exc_badaddr <= exc_any ? r_aluresult : 32'h0;
        end
    end

endmodule
